// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the configurable UART receive path.
// Parity modes, receiver FSM states and the 3-sample majority vote.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Word delivery handshake between the receiver and its consumer.
// master: receiver side (drives word + flags), slave: consumer (drives i_rd).
interface uart_rx_cfg_if #(
  parameter int DBIT = 8
);

  logic            i_rd;
  logic            o_valid;
  logic [DBIT-1:0] o_data;
  logic            o_parity_err;
  logic            o_frame_err;
  logic            o_break;
  logic            o_overrun;

  modport master (
    input  i_rd,
    output o_valid, o_data, o_parity_err,
    output o_frame_err, o_break, o_overrun
  );

  modport slave (
    output i_rd,
    input  o_valid, o_data, o_parity_err,
    input  o_frame_err, o_break, o_overrun
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-clock tick every i_dvsr+1 clocks.
// Ports: i_clk, i_reset (async, active-low), i_dvsr (period-1), o_tick.
module uart_baud_gen #(
  parameter int DVSR_BIT = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [DVSR_BIT-1:0] i_dvsr,
  output logic                o_tick
);

  logic [DVSR_BIT-1:0] r_cnt;
  logic                w_tick;

  assign w_tick = (r_cnt == i_dvsr);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with majority sampling and error flags.
// Ports: i_clk, i_reset, i_rx, i_dvsr, i_parity_mode, i_two_stop, rx_if, o_busy.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int SB_TICK     = 16,
  parameter int DVSR_BIT    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_rx,
  input  logic [DVSR_BIT-1:0] i_dvsr,
  input  logic [1:0]          i_parity_mode,
  input  logic                i_two_stop,
  uart_rx_cfg_if.master       rx_if,
  output logic                o_busy
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = $clog2(DBIT) + 1;
  localparam logic [SW-1:0] S_LO  = SW'(SB_TICK/2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(SB_TICK/2);
  localparam logic [SW-1:0] S_HI  = SW'(SB_TICK/2 + 1);
  localparam logic [SW-1:0] S_END = SW'(SB_TICK - 1);

  logic                   w_tick;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;

  rx_state_t       r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_data;
  logic [2:0]      r_smp;
  logic [1:0]      r_par;
  logic            r_two;
  logic            r_stop2;
  logic            r_pbit;
  logic            r_perr;
  logic            r_fe;
  logic            r_brk;
  logic            r_commit;

  logic            w_maj;
  logic            w_maj_live;
  logic            w_par_en;
  logic            w_fe_now;

  logic            r_valid;
  logic [DBIT-1:0] r_hdata;
  logic            r_hperr;
  logic            r_hfe;
  logic            r_hbrk;
  logic            r_ovr;

  uart_baud_gen #(
    .DVSR_BIT(DVSR_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_dvsr (i_dvsr),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
    end
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

  // START decides on the tick of the third sample, so it votes with
  // the live line; later bits vote at bit end from stored samples.
  assign w_maj_live = maj3(r_smp[0], r_smp[1], w_rxs);
  assign w_maj      = maj3(r_smp[0], r_smp[1], r_smp[2]);
  assign w_par_en   = (r_par == PAR_EVEN) || (r_par == PAR_ODD);
  assign w_fe_now   = r_fe | ~w_maj;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_s      <= '0;
      r_n      <= '0;
      r_data   <= '0;
      r_smp    <= '0;
      r_par    <= PAR_NONE;
      r_two    <= 1'b0;
      r_stop2  <= 1'b0;
      r_pbit   <= 1'b0;
      r_perr   <= 1'b0;
      r_fe     <= 1'b0;
      r_brk    <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (w_tick) begin
        if (r_s == S_LO)  r_smp[0] <= w_rxs;
        if (r_s == S_MID) r_smp[1] <= w_rxs;
        if (r_s == S_HI)  r_smp[2] <= w_rxs;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            r_state <= ST_START;
            r_s     <= '0;
            r_par   <= i_parity_mode;
            r_two   <= i_two_stop;
            r_stop2 <= 1'b0;
            r_pbit  <= 1'b0;
            r_perr  <= 1'b0;
            r_fe    <= 1'b0;
            r_brk   <= 1'b0;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (r_s == S_HI) begin
              if (!w_maj_live) begin
                r_state <= ST_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_s == S_END) begin
              r_s    <= '0;
              r_data <= {w_maj, r_data[DBIT-1:1]};
              if (r_n == NW'(DBIT - 1)) begin
                r_state <= w_par_en ? ST_PARITY : ST_STOP;
              end else begin
                r_n <= r_n + 1'b1;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            if (r_s == S_END) begin
              r_s     <= '0;
              r_pbit  <= w_maj;
              r_perr  <= (^r_data) ^ w_maj ^ (r_par == PAR_ODD);
              r_state <= ST_STOP;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_s == S_END) begin
              r_s  <= '0;
              r_fe <= w_fe_now;
              if (!r_stop2) begin
                r_brk <= (r_data == '0) & ~r_pbit & ~w_maj;
              end
              if (r_two && !r_stop2) begin
                r_stop2 <= 1'b1;
              end else begin
                r_commit <= 1'b1;
                r_state  <= w_fe_now ? ST_WAIT_IDLE : ST_IDLE;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (w_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Frame results stay in r_data/r_perr/r_fe/r_brk until the next
  // START, so the holding register can take them one clock later.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid <= 1'b0;
      r_hdata <= '0;
      r_hperr <= 1'b0;
      r_hfe   <= 1'b0;
      r_hbrk  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (r_commit) begin
      if (!r_valid || rx_if.i_rd) begin
        r_valid <= 1'b1;
        r_hdata <= r_data;
        r_hperr <= r_perr;
        r_hfe   <= r_fe;
        r_hbrk  <= r_brk;
        if (r_valid) r_ovr <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (rx_if.i_rd && r_valid) begin
      r_valid <= 1'b0;
      r_hperr <= 1'b0;
      r_hfe   <= 1'b0;
      r_hbrk  <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign rx_if.o_valid      = r_valid;
  assign rx_if.o_data       = r_hdata;
  assign rx_if.o_parity_err = r_hperr;
  assign rx_if.o_frame_err  = r_hfe;
  assign rx_if.o_break      = r_hbrk;
  assign rx_if.o_overrun    = r_ovr;
  assign o_busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames plus randomized frames
// checked against a word-level model of the receiver and holding register.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int BITC = 80;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] dvsr = 16'd4;
  logic [1:0]  pmode = PAR_NONE;
  logic        two = 1'b0;
  logic        busy;

  uart_rx_cfg_if #(.DBIT(8)) bus ();

  uart_rx_cfg #(
    .DBIT(8), .SB_TICK(16), .DVSR_BIT(16), .SYNC_STAGES(2)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_rx         (rx),
    .i_dvsr       (dvsr),
    .i_parity_mode(pmode),
    .i_two_stop   (two),
    .rx_if        (bus),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  bit    settled = 1'b0;
  word_t m_word = '0;
  bit    m_valid = 1'b0;
  bit    m_ovr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Word the receiver must deliver for a frame, from the line contents.
  function automatic word_t expect_word(input logic [7:0] d,
    input logic [1:0] mode, input logic pbit, input logic s0,
    input logic s1, input logic tw);
    word_t w;
    bit    pen;
    int    ones;
    pen   = (mode == PAR_EVEN) || (mode == PAR_ODD);
    ones  = $countones(d) + ((pen && pbit) ? 1 : 0);
    w.d   = d;
    w.pe  = pen && ((mode == PAR_EVEN) ? (ones % 2 != 0) : (ones % 2 == 0));
    w.fe  = !s0 || (tw && !s1);
    w.brk = (d == 8'h00) && (!pen || !pbit) && !s0;
    return w;
  endfunction

  task automatic m_commit(input word_t w);
    if (!m_valid) begin
      m_word  = w;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (settled) begin
      chk("valid", bus.o_valid, m_valid);
      chk("overrun", bus.o_overrun, m_ovr);
      chk("busy", busy, 1'b0);
      if (m_valid) begin
        chk("data", bus.o_data, m_word.d);
        chk("perr", bus.o_parity_err, m_word.pe);
        chk("ferr", bus.o_frame_err, m_word.fe);
        chk("brk", bus.o_break, m_word.brk);
      end else begin
        chk("flags_idle", {bus.o_parity_err, bus.o_frame_err,
                           bus.o_break}, 3'b000);
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
    input logic tw, input logic flip, input logic s0, input logic s1,
    input bit scr);
    logic pbit;
    bit   pen;
    settled = 1'b0;
    pmode   = mode;
    two     = tw;
    pen     = (mode == PAR_EVEN) || (mode == PAR_ODD);
    pbit    = ((mode == PAR_ODD) ? ~^d : ^d) ^ flip;
    rx = 1'b0;
    wclk(BITC);
    if (scr) begin
      pmode = 2'($urandom_range(0, 3));
      two   = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wclk(BITC);
    end
    if (pen) begin
      rx = pbit;
      wclk(BITC);
    end
    rx = s0;
    wclk(BITC);
    if (tw) begin
      rx = s1;
      wclk(BITC);
    end
    rx = 1'b1;
    wclk(200);
    m_commit(expect_word(d, mode, pbit, s0, s1, tw));
    settled = 1'b1;
  endtask

  task automatic do_read();
    @(negedge clk);
    settled  = 1'b0;
    bus.i_rd = 1'b1;
    @(negedge clk);
    bus.i_rd = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    settled = 1'b1;
  endtask

  task automatic watch_valid();
    int k;
    k = 0;
    while (!busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t1_busy_rise", busy, 1'b1);
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("t1_busy_fall", busy, 1'b0);
    k = 0;
    while (!bus.o_valid && k < 3) begin
      @(negedge clk);
      k++;
    end
    chk("t1_valid_le2clk", (k <= 2), 1'b1);
  endtask

  initial begin
    word_t      w;
    logic [7:0] d;
    logic [1:0] md;
    logic       tw, fl, s0, s1;
    bus.i_rd = 1'b0;

    w = expect_word(8'h07, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("pin_even_ok", w.pe, 1'b0);
    w = expect_word(8'h07, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pin_even_bad", w.pe, 1'b1);
    w = expect_word(8'h07, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("pin_odd_ok", w.pe, 1'b0);
    w = expect_word(8'h00, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pin_brk", {w.brk, w.fe}, 2'b11);
    w = expect_word(8'h3C, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pin_fe_nobrk", {w.brk, w.fe}, 2'b01);

    #23;
    chk("reset_out", {bus.o_valid, bus.o_data, bus.o_parity_err,
        bus.o_frame_err, bus.o_break, bus.o_overrun, busy}, 0);
    rst_n = 1'b1;
    wclk(20);
    settled = 1'b1;

    fork
      send_frame(8'hA5, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      watch_valid();
    join
    chk("t1_data", bus.o_data, 8'hA5);
    chk("t1_flags", {bus.o_parity_err, bus.o_frame_err, bus.o_break}, 0);
    do_read();

    send_frame(8'h07, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t2_pe_ok", bus.o_parity_err, 1'b0);
    do_read();
    send_frame(8'h07, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_pe_bad", bus.o_parity_err, 1'b1);
    chk("t2_data", bus.o_data, 8'h07);
    do_read();

    send_frame(8'h3C, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_fe", {bus.o_frame_err, bus.o_break}, 2'b10);
    do_read();

    settled = 1'b0;
    pmode   = PAR_NONE;
    two     = 1'b0;
    rx      = 1'b0;
    wclk(BITC * 10 + 400);
    chk("t3_brk_hold_busy", busy, 1'b1);
    chk("t3_brk_word", {bus.o_valid, bus.o_break, bus.o_frame_err}, 3'b111);
    rx = 1'b1;
    wclk(200);
    m_commit(expect_word(8'h00, PAR_NONE, 1'b0, 1'b0, 1'b0, 1'b0));
    settled = 1'b1;
    do_read();
    wclk(2);
    chk("t3_one_word", bus.o_valid, 1'b0);

    settled = 1'b0;
    rx = 1'b0;
    wclk(15);
    rx = 1'b1;
    wclk(50);
    chk("t4_glitch_busy", busy, 1'b0);
    chk("t4_glitch_novalid", bus.o_valid, 1'b0);
    settled = 1'b1;

    send_frame(8'h11, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_held", {bus.o_data, bus.o_overrun}, {8'h11, 1'b1});
    do_read();
    chk("t5_read", {bus.o_valid, bus.o_overrun}, 2'b00);
    send_frame(8'h55, PAR_NONE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_two_stop_fe", bus.o_frame_err, 1'b1);

    settled = 1'b0;
    d  = 8'h5A;
    rx = 1'b0;
    wclk(BITC);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      wclk(BITC);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_reset", {bus.o_valid, bus.o_data, bus.o_parity_err,
        bus.o_frame_err, bus.o_break, bus.o_overrun, busy}, 0);
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    rx = 1'b1;
    wclk(10);
    rst_n = 1'b1;
    wclk(100);
    settled = 1'b1;
    send_frame(8'h5A, PAR_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_data", bus.o_data, 8'h5A);
    do_read();

    for (int it = 0; it < 30; it++) begin
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      md = 2'($urandom_range(0, 3));
      tw = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 3) == 0);
      s0 = ($urandom_range(0, 7) != 0);
      s1 = ($urandom_range(0, 7) != 0);
      send_frame(d, md, tw, fl, s0, s1, 1'b1);
      wclk($urandom_range(0, 100));
      if ($urandom_range(0, 1) == 1) do_read();
    end

    wclk(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
